// File: rtl/aes_inv_key_regs.sv
// Byte-serial inverse AES-128 key-schedule register: loads the round-10 key,
// steps back one round key per request through a shared S-box, and streams the current key out.
module aes_inv_key_regs #(
    parameter int         NB_BYTES  = 16,
    parameter logic [7:0] RCON_LAST = 8'h36
) (
    input  logic       ClkxCI,
    input  logic       RstxRI,
    input  logic [7:0] KeyInxDI,
    input  logic       KeyInValidxSI,
    input  logic       StartxSI,
    input  logic       ReadxSI,
    output logic [7:0] SboxOutxDO,
    input  logic [7:0] SboxInxDI,
    output logic [7:0] KeyOutxDO,
    output logic       KeyOutValidxSO,
    output logic [3:0] RoundxDO,
    output logic       BusyxSO,
    output logic       DonexSO
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_STEP = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [3:0] ROUND_LAST = 4'd10;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic [7:0] key_q [NB_BYTES];
    logic [7:0] key_d [NB_BYTES];

    // Single byte write port shared by loading and key-schedule steps.
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    logic [3:0] step_addr;
    logic [3:0] step_src;
    logic [3:0] sbox_addr;
    logic [7:0] step_operand;
    logic [7:0] step_val;
    logic       sbox_phase;

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1B) >> 1) | 8'h80) : (x >> 1);
    endfunction

    assign sbox_phase = (state_q == ST_STEP) && (cnt_q[3:2] == 2'b11);
    // RotWord of the freshly updated w3 feeds the S-box: row k+1 of word 3.
    assign sbox_addr  = {2'b11, cnt_q[1:0] + 2'd1};

    always_comb begin
        step_addr = 4'd0;
        step_src  = 4'd0;
        case (cnt_q[3:2])
            2'd0: begin
                step_addr = cnt_q + 4'd12;
                step_src  = cnt_q + 4'd8;
            end
            2'd1: begin
                step_addr = cnt_q + 4'd4;
                step_src  = cnt_q;
            end
            2'd2: begin
                step_addr = cnt_q - 4'd4;
                step_src  = cnt_q - 4'd8;
            end
            default: begin
                step_addr = {2'b00, cnt_q[1:0]};
                step_src  = {2'b00, cnt_q[1:0]};
            end
        endcase
    end

    always_comb begin
        step_operand = key_q[step_src];
        if (cnt_q[3:2] == 2'b11) begin
            step_operand = SboxInxDI ^ ((cnt_q[1:0] == 2'd0) ? rcon_q : 8'h00);
        end
        step_val = key_q[step_addr] ^ step_operand;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = KeyInxDI;
        case (state_q)
            ST_IDLE: begin
                if (KeyInValidxSI) begin
                    wr_en   = 1'b1;
                    wr_addr = 4'd0;
                    cnt_d   = 4'd1;
                    state_d = ST_LOAD;
                end else if (StartxSI && (round_q != 4'd0)) begin
                    cnt_d   = 4'd0;
                    state_d = ST_STEP;
                end else if (ReadxSI) begin
                    cnt_d   = 4'd0;
                    state_d = ST_READ;
                end
            end
            ST_LOAD: begin
                if (KeyInValidxSI) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        round_d = ROUND_LAST;
                        rcon_d  = RCON_LAST;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STEP: begin
                wr_en   = 1'b1;
                wr_addr = step_addr;
                wr_data = step_val;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    round_d = round_q - 4'd1;
                    rcon_d  = inv_xtime(rcon_q);
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NB_BYTES; gi++) begin : g_key_next
        assign key_d[gi] = (wr_en && (wr_addr == 4'(gi))) ? wr_data : key_q[gi];
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            round_q <= 4'd0;
            rcon_q  <= RCON_LAST;
            for (int i = 0; i < NB_BYTES; i++) begin
                key_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            for (int i = 0; i < NB_BYTES; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

    assign SboxOutxDO     = sbox_phase ? key_q[sbox_addr] : 8'h00;
    assign KeyOutValidxSO = (state_q == ST_READ);
    assign KeyOutxDO      = (state_q == ST_READ) ? key_q[cnt_q] : 8'h00;
    assign RoundxDO       = round_q;
    assign BusyxSO        = (state_q == ST_LOAD) || (state_q == ST_STEP) || (state_q == ST_READ);
    assign DonexSO        = (state_q == ST_DONE);

endmodule
